// File: rtl/control_sequencer_pkg.sv
// Shared types and constants for the control sequencer: FSM states, opcode
// values, instruction-register field positions and ALU select codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  localparam logic [4:0] OP_MUL  = 5'b01100;
  localparam logic [4:0] OP_DIV  = 5'b01101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  // ALU select is driven only in T4; everywhere else it rests at ALU_NONE.
  localparam logic [3:0] ALU_NONE = 4'b0000;

  function automatic logic [3:0] alu_code(input logic [4:0] opcode);
    return opcode[3:0];
  endfunction

endpackage

// File: rtl/control_sequencer_reg_decoder.sv
// 4-to-16 one-hot decoder with enable; used for register load and drive selects.
module reg_decoder (
  input  logic [3:0]  i_sel,
  input  logic        i_en,
  output logic [15:0] o_onehot
);

  assign o_onehot = i_en ? (16'h0001 << i_sel) : 16'h0000;

endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2), decode (T3), execute (T4-T6), HALT.
// Define R0_ZERO_EN to make R0 read-only (RIn[0] never asserted).
module control_sequencer
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        MemReady,
  input  logic [31:0] IR,
  output logic [15:0] RIn,
  output logic [15:0] ROut,
  output logic        PCOut,
  output logic        PCIn,
  output logic        IncPC,
  output logic        MARIn,
  output logic        MDRIn,
  output logic        MDRead,
  output logic        MDROut,
  output logic        IRIn,
  output logic        RYIn,
  output logic        ZLowIn,
  output logic        ZHighIn,
  output logic        ZLowOut,
  output logic        ZHighOut,
  output logic        LOWIn,
  output logic        HIIn,
  output logic [3:0]  ALUcontrol,
  output logic        Halted,
  output logic        IllegalOp,
  output state_t      dbg_state
);

  state_t     r_state;
  state_t     w_next_state;
  logic       r_t1_wait;
  logic [4:0] w_opcode;
  logic [3:0] w_ra;
  logic [3:0] w_rb;
  logic [3:0] w_rc;
  logic       w_muldiv;
  logic       w_ra_writable;
  logic       w_rin_en;
  logic       w_rout_en;
  logic [3:0] w_rout_sel;
  logic       w_unused_ir;

  assign w_opcode    = IR[OPC_MSB:OPC_LSB];
  assign w_ra        = IR[RA_MSB:RA_LSB];
  assign w_rb        = IR[RB_MSB:RB_LSB];
  assign w_rc        = IR[RC_MSB:RC_LSB];
  assign w_muldiv    = (w_opcode == OP_MUL) || (w_opcode == OP_DIV);
  assign w_unused_ir = ^IR[RC_LSB-1:0];
  assign dbg_state   = r_state;

`ifdef R0_ZERO_EN
  assign w_ra_writable = (w_ra != 4'd0);
`else
  assign w_ra_writable = 1'b1;
`endif

  // r_t1_wait marks T1 cycles after the first, so PCIn fires only once per fetch.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_t1_wait <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_t1_wait <= (r_state == T1) && !MemReady;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: w_next_state = run ? T0 : IDLE;
      T0:   w_next_state = T1;
      T1:   w_next_state = MemReady ? T2 : T1;
      T2:   w_next_state = T3;
      T3: begin
        if (!w_opcode[4])              w_next_state = T4;
        else if (w_opcode == OP_HALT)  w_next_state = HALT;
        else                           w_next_state = run ? T0 : IDLE;
      end
      T4:   w_next_state = T5;
      T5:   w_next_state = w_muldiv ? T6 : (run ? T0 : IDLE);
      T6:   w_next_state = run ? T0 : IDLE;
      HALT: w_next_state = HALT;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    PCOut      = 1'b0;
    PCIn       = 1'b0;
    IncPC      = 1'b0;
    MARIn      = 1'b0;
    MDRIn      = 1'b0;
    MDRead     = 1'b0;
    MDROut     = 1'b0;
    IRIn       = 1'b0;
    RYIn       = 1'b0;
    ZLowIn     = 1'b0;
    ZHighIn    = 1'b0;
    ZLowOut    = 1'b0;
    ZHighOut   = 1'b0;
    LOWIn      = 1'b0;
    HIIn       = 1'b0;
    ALUcontrol = ALU_NONE;
    Halted     = 1'b0;
    IllegalOp  = 1'b0;
    w_rin_en   = 1'b0;
    w_rout_en  = 1'b0;
    w_rout_sel = w_rb;
    case (r_state)
      T0: begin
        PCOut  = 1'b1;
        MARIn  = 1'b1;
        IncPC  = 1'b1;
        ZLowIn = 1'b1;
      end
      T1: begin
        ZLowOut = 1'b1;
        PCIn    = !r_t1_wait;
        MDRead  = 1'b1;
        MDRIn   = 1'b1;
      end
      T2: begin
        MDROut = 1'b1;
        IRIn   = 1'b1;
      end
      T3: begin
        if (!w_opcode[4]) begin
          w_rout_en = 1'b1;
          RYIn      = 1'b1;
        end else if (w_opcode != OP_HALT) begin
          IllegalOp = 1'b1;
        end
      end
      T4: begin
        w_rout_en  = 1'b1;
        w_rout_sel = w_rc;
        ALUcontrol = alu_code(w_opcode);
        ZLowIn     = 1'b1;
        ZHighIn    = 1'b1;
      end
      T5: begin
        ZLowOut = 1'b1;
        if (w_muldiv) LOWIn = 1'b1;
        else          w_rin_en = w_ra_writable;
      end
      T6: begin
        ZHighOut = 1'b1;
        HIIn     = 1'b1;
      end
      HALT: Halted = 1'b1;
      default: ;
    endcase
  end

  reg_decoder u_rin_dec (
    .i_sel    (w_ra),
    .i_en     (w_rin_en),
    .o_onehot (RIn)
  );

  reg_decoder u_rout_dec (
    .i_sel    (w_rout_sel),
    .i_en     (w_rout_en),
    .o_onehot (ROut)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level reference model expands each
// instruction into its expected per-cycle strobe trace, then replays it.
module tb_control_sequencer;
  import ctrl_pkg::*;

  localparam int EW = 53;
  localparam int W  = 32 + 2 + EW;

  localparam logic [14:0] M_PCOUT    = 15'h4000;
  localparam logic [14:0] M_PCIN     = 15'h2000;
  localparam logic [14:0] M_INCPC    = 15'h1000;
  localparam logic [14:0] M_MARIN    = 15'h0800;
  localparam logic [14:0] M_MDRIN    = 15'h0400;
  localparam logic [14:0] M_MDREAD   = 15'h0200;
  localparam logic [14:0] M_MDROUT   = 15'h0100;
  localparam logic [14:0] M_IRIN     = 15'h0080;
  localparam logic [14:0] M_RYIN     = 15'h0040;
  localparam logic [14:0] M_ZLOWIN   = 15'h0020;
  localparam logic [14:0] M_ZHIGHIN  = 15'h0010;
  localparam logic [14:0] M_ZLOWOUT  = 15'h0008;
  localparam logic [14:0] M_ZHIGHOUT = 15'h0004;
  localparam logic [14:0] M_LOWIN    = 15'h0002;
  localparam logic [14:0] M_HIIN     = 15'h0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        MemReady;
  logic [31:0] IR;
  logic [15:0] RIn, ROut;
  logic        PCOut, PCIn, IncPC, MARIn, MDRIn, MDRead, MDROut, IRIn, RYIn;
  logic        ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOWIn, HIIn;
  logic [3:0]  ALUcontrol;
  logic        Halted, IllegalOp;
  state_t      dbg_state;

  int checks = 0;
  int errors = 0;
  bit model_idle;
  logic [W-1:0] exp_q[$];
  logic [EW-1:0] act;

  always #5 clk = ~clk;

  control_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .MemReady(MemReady), .IR(IR),
    .RIn(RIn), .ROut(ROut), .PCOut(PCOut), .PCIn(PCIn), .IncPC(IncPC),
    .MARIn(MARIn), .MDRIn(MDRIn), .MDRead(MDRead), .MDROut(MDROut),
    .IRIn(IRIn), .RYIn(RYIn), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .ZLowOut(ZLowOut), .ZHighOut(ZHighOut), .LOWIn(LOWIn), .HIIn(HIIn),
    .ALUcontrol(ALUcontrol), .Halted(Halted), .IllegalOp(IllegalOp),
    .dbg_state(dbg_state)
  );

  assign act = {RIn, ROut, PCOut, PCIn, IncPC, MARIn, MDRIn, MDRead, MDROut,
                IRIn, RYIn, ZLowIn, ZHighIn, ZLowOut, ZHighOut, LOWIn, HIIn,
                ALUcontrol, Halted, IllegalOp};

  function automatic logic [EW-1:0] mk(input logic [15:0] rin, input logic [15:0] rout,
                                       input logic [14:0] s, input logic [3:0] alu,
                                       input logic h, input logic il);
    return {rin, rout, s, alu, h, il};
  endfunction

  function automatic logic [15:0] onehot(input logic [3:0] n);
    logic [15:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic logic run_at(input int idx, input int drop_at);
    return (drop_at >= 0 && idx >= drop_at) ? 1'b0 : 1'b1;
  endfunction

  task automatic push_cyc(input logic [31:0] ir, input logic rv, input logic mv,
                          input logic [EW-1:0] e);
    exp_q.push_back({ir, rv, mv, e});
  endtask

  // Reference model: one instruction -> expected cycle trace plus the run/MemReady to drive.
  task automatic model_instr(input logic [31:0] ir, input int waits, input int drop_at,
                             output int pos_t4);
    logic [4:0]  op;
    logic [3:0]  ra, rb, rc;
    logic [15:0] rin;
    logic        last_rv;
    bit          muldiv;
    int          idx;
    op = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
    muldiv = (op == 5'b01100) || (op == 5'b01101);
    idx = 0;
    pos_t4 = -1;
    if (model_idle) push_cyc(ir, 1'b1, 1'($urandom_range(0, 1)), '0);
    push_cyc(ir, run_at(idx, drop_at), 1'($urandom_range(0, 1)),
             mk(16'h0, 16'h0, M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN, 4'h0, 1'b0, 1'b0));
    idx++;
    for (int i = 0; i <= waits; i++) begin
      push_cyc(ir, run_at(idx, drop_at), (i == waits),
               mk(16'h0, 16'h0, M_ZLOWOUT | M_MDREAD | M_MDRIN | ((i == 0) ? M_PCIN : 15'h0),
                  4'h0, 1'b0, 1'b0));
      idx++;
    end
    push_cyc(ir, run_at(idx, drop_at), 1'($urandom_range(0, 1)),
             mk(16'h0, 16'h0, M_MDROUT | M_IRIN, 4'h0, 1'b0, 1'b0));
    idx++;
    last_rv = run_at(idx, drop_at);
    if (!op[4]) begin
      push_cyc(ir, run_at(idx, drop_at), 1'($urandom_range(0, 1)),
               mk(16'h0, onehot(rb), M_RYIN, 4'h0, 1'b0, 1'b0));
      idx++;
      pos_t4 = exp_q.size();
      push_cyc(ir, run_at(idx, drop_at), 1'($urandom_range(0, 1)),
               mk(16'h0, onehot(rc), M_ZLOWIN | M_ZHIGHIN, op[3:0], 1'b0, 1'b0));
      idx++;
      rin = onehot(ra);
`ifdef R0_ZERO_EN
      if (ra == 4'd0) rin = 16'h0;
`endif
      last_rv = run_at(idx, drop_at);
      if (muldiv) begin
        push_cyc(ir, last_rv, 1'($urandom_range(0, 1)),
                 mk(16'h0, 16'h0, M_ZLOWOUT | M_LOWIN, 4'h0, 1'b0, 1'b0));
        idx++;
        last_rv = run_at(idx, drop_at);
        push_cyc(ir, last_rv, 1'($urandom_range(0, 1)),
                 mk(16'h0, 16'h0, M_ZHIGHOUT | M_HIIN, 4'h0, 1'b0, 1'b0));
      end else begin
        push_cyc(ir, last_rv, 1'($urandom_range(0, 1)),
                 mk(rin, 16'h0, M_ZLOWOUT, 4'h0, 1'b0, 1'b0));
      end
      model_idle = !last_rv;
    end else if (op == 5'b11111) begin
      push_cyc(ir, last_rv, 1'($urandom_range(0, 1)), '0);
    end else begin
      push_cyc(ir, last_rv, 1'($urandom_range(0, 1)),
               mk(16'h0, 16'h0, 15'h0, 4'h0, 1'b0, 1'b1));
      model_idle = !last_rv;
    end
  endtask

  // Scoreboard: drive each record just after a rising edge, compare on the falling edge.
  task automatic run_records(input int n);
    logic [W-1:0] rec;
    for (int k = 0; k < n; k++) begin
      rec = exp_q.pop_front();
      IR = rec[W-1 -: 32];
      run = rec[EW+1];
      MemReady = rec[EW];
      @(negedge clk);
      checks++;
      if (act !== rec[EW-1:0]) begin
        errors++;
        $display("FAIL trace step %0d t=%0t: outputs %h expected %h (IR %h)",
                 k, $time, act, rec[EW-1:0], rec[W-1 -: 32]);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_all();
    run_records(exp_q.size());
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) push_cyc(IR, 1'b0, 1'($urandom_range(0, 1)), '0);
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] op, input logic [3:0] ra);
    return {op, ra, 4'($urandom), 4'($urandom), 15'($urandom)};
  endfunction

  task automatic test_reset();
    reset = 1'b0; run = 1'b1; MemReady = 1'b1; IR = 32'h4A920000;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (act !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", act);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state: got %0d expected IDLE", dbg_state);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_idle = 1'b1;
    push_idle(3);
    run_all();
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL idle_hold: got %0d expected IDLE", dbg_state);
    end
  endtask

  task automatic test_alu_example();
    int p;
    model_instr(32'h4A920000, 0, -1, p);
    run_all();
  endtask

  task automatic test_muldiv();
    int p;
    model_instr(mk_ir(5'b01100, 4'd1), 0, -1, p);
    model_instr(mk_ir(5'b01101, 4'($urandom)), 1, -1, p);
    run_all();
  endtask

  task automatic test_t1_wait();
    int p;
    model_instr(mk_ir(5'($urandom_range(0, 15)), 4'($urandom)), 3, -1, p);
    run_all();
  endtask

  task automatic test_illegal();
    int p;
    model_instr(32'h80000000, 0, -1, p);
    model_instr(mk_ir(5'($urandom_range(16, 30)), 4'($urandom)), 2, -1, p);
    run_all();
  endtask

  task automatic test_r0();
    int p;
    model_instr(mk_ir(5'b00011, 4'd0), 0, -1, p);
    model_instr(mk_ir(5'b00111, 4'd0), 1, -1, p);
    run_all();
  endtask

  task automatic test_run_drop();
    int p;
    model_instr(mk_ir(5'b00101, 4'd7), 0, 3, p);
    run_all();
    push_idle(3);
    run_all();
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL run_drop_state: got %0d expected IDLE", dbg_state);
    end
    model_instr(mk_ir(5'b01101, 4'd2), 0, 5, p);
    run_all();
  endtask

  task automatic test_random();
    int p;
    logic [4:0] op;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 7) op = 5'($urandom_range(0, 15));
      else                          op = 5'($urandom_range(16, 30));
      model_instr(mk_ir(op, 4'($urandom)), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1, p);
      if (model_idle && $urandom_range(0, 1) == 1) push_idle($urandom_range(1, 3));
    end
    run_all();
  endtask

  task automatic test_reset_t4();
    int p;
    logic [31:0] ir;
    ir = mk_ir(5'b01001, 4'd5);
    model_instr(ir, 1, -1, p);
    run_records(p);
    exp_q.delete();
    checks++;
    if (ROut !== onehot(ir[18:15]) || ALUcontrol !== ir[30:27]) begin
      errors++; $display("FAIL t4_before_reset: ROut %h ALU %h expected %h %h",
                         ROut, ALUcontrol, onehot(ir[18:15]), ir[30:27]);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (act !== '0 || dbg_state !== IDLE) begin
      errors++; $display("FAIL async_reset_t4: outputs %h state %0d expected 0 IDLE",
                         act, dbg_state);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_idle = 1'b1;
    model_instr(mk_ir(5'b00010, 4'd9), 0, -1, p);
    run_all();
  endtask

  task automatic test_halt();
    int p;
    model_instr(32'hF8000000, 0, -1, p);
    for (int i = 0; i < 20; i++)
      push_cyc(32'hF8000000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               mk(16'h0, 16'h0, 15'h0, 4'h0, 1'b1, 1'b0));
    run_all();
    checks++;
    if (dbg_state !== HALT) begin
      errors++; $display("FAIL halt_state: got %0d expected HALT", dbg_state);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (Halted !== 1'b0 || act !== '0) begin
      errors++; $display("FAIL halt_reset: Halted %b outputs %h expected 0", Halted, act);
    end
    run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_idle = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_example();
    test_muldiv();
    test_t1_wait();
    test_illegal();
    test_r0();
    test_run_drop();
    test_random();
    test_reset_t4();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
